bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/axi.sv | 36 +++
 rtl/bus_arbiter_arb_pick.sv | 50 +++++
 rtl/bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the cache-port arbiter.
package bus_arbiter_pkg;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned WPEND_W = 3;

   typedef enum logic [1:0] {IDLE, ADDR, RESP} arb_state_t;
   typedef logic [1:0] grant_t;

   localparam grant_t GRANT_NONE  = 2'b00;
   localparam grant_t GRANT_INSTR = 2'b01;
   localparam grant_t GRANT_DATA  = 2'b10;
endpackage

// File: rtl/axi.sv
// Single-beat AXI-lite style channel bundle used by all arbiter ports.
interface axi;
   import bus_arbiter_pkg::*;

   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
             wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
             wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// Two-request picker: fixed priority, or round-robin when BUS_ARBITER_RR_EN is defined.
module arb_pick
   import bus_arbiter_pkg::*;
`ifndef BUS_ARBITER_RR_EN
#(
   parameter bit PRIO_DATA = 1'b1
)
`endif
(
`ifdef BUS_ARBITER_RR_EN
   input  logic   clk,
   input  logic   rst,
   input  logic   advance,
`endif
   input  logic   req_instr,
   input  logic   req_data,
   output grant_t pick_c
);

`ifdef BUS_ARBITER_RR_EN
   // 1 = data was granted last; reset favours data on the first contention
   logic last_grant_q, last_grant_d;

   always_comb begin
      last_grant_d = last_grant_q;
      if (advance) last_grant_d = (pick_c == GRANT_DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) last_grant_q <= 1'b0;
      else     last_grant_q <= last_grant_d;
   end
`endif

   always_comb begin
      pick_c = GRANT_NONE;
      if (req_instr && req_data) begin
`ifdef BUS_ARBITER_RR_EN
         pick_c = last_grant_q ? GRANT_INSTR : GRANT_DATA;
`else
         pick_c = PRIO_DATA ? GRANT_DATA : GRANT_INSTR;
`endif
      end else if (req_data) begin
         pick_c = GRANT_DATA;
      end else if (req_instr) begin
         pick_c = GRANT_INSTR;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the cache AXI port between fetch (read-only) and memory stage (read/write).
// Optional round-robin read arbitration via BUS_ARBITER_RR_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WR    = 2,
   parameter bit          PRIO_DATA = 1'b1
) (
   input  logic               aclk,
   input  logic               areset,
   axi.slave                  instr,
   axi.slave                  data,
   axi.master                 cache,
   output grant_t             grant,
   output logic [WPEND_W-1:0] wr_pending
);

   arb_state_t         state_q, state_d;
   grant_t             grant_q, grant_d;
   logic [WPEND_W-1:0] wr_pending_q, wr_pending_d;
   grant_t             pick_c;
   logic               start_c, wr_open_c, sel_data_c;
   logic               ar_hs_c, r_hs_c, aw_hs_c, b_hs_c;

   assign sel_data_c = grant_q[1];
   assign start_c    = (state_q == IDLE) && (wr_pending_q == '0) &&
                       (instr.arvalid || data.arvalid);
   // writes only flow while no read is in flight or starting this cycle
   assign wr_open_c  = !areset && (state_q == IDLE) && !start_c &&
                       (wr_pending_q < WPEND_W'(MAX_WR));

`ifdef BUS_ARBITER_RR_EN
   arb_pick u_pick (
      .clk       (aclk),
      .rst       (areset),
      .advance   (start_c),
      .req_instr (instr.arvalid),
      .req_data  (data.arvalid),
      .pick_c    (pick_c)
   );
`else
   arb_pick #(.PRIO_DATA(PRIO_DATA)) u_pick (
      .req_instr (instr.arvalid),
      .req_data  (data.arvalid),
      .pick_c    (pick_c)
   );
`endif

   // Read channel steering towards the granted master
   always_comb begin
      cache.arvalid = 1'b0;
      cache.araddr  = sel_data_c ? data.araddr : instr.araddr;
      cache.arprot  = sel_data_c ? data.arprot : instr.arprot;
      cache.rready  = 1'b0;
      instr.arready = 1'b0;
      data.arready  = 1'b0;
      instr.rvalid  = 1'b0;
      data.rvalid   = 1'b0;
      if (state_q == ADDR) begin
         cache.arvalid = sel_data_c ? data.arvalid : instr.arvalid;
         if (sel_data_c) data.arready  = cache.arready;
         else            instr.arready = cache.arready;
      end else if (state_q == RESP) begin
         cache.rready = sel_data_c ? data.rready : instr.rready;
         if (sel_data_c) data.rvalid  = cache.rvalid;
         else            instr.rvalid = cache.rvalid;
      end
   end

   assign instr.rdata = cache.rdata;
   assign instr.rresp = cache.rresp;
   assign data.rdata  = cache.rdata;
   assign data.rresp  = cache.rresp;

   assign cache.awvalid = data.awvalid & wr_open_c;
   assign data.awready  = cache.awready & wr_open_c;
   assign cache.awaddr  = data.awaddr;
   assign cache.awprot  = data.awprot;
   assign cache.wvalid  = data.wvalid & wr_open_c;
   assign data.wready   = cache.wready & wr_open_c;
   assign cache.wdata   = data.wdata;
   assign cache.wstrb   = data.wstrb;
   assign data.bvalid   = cache.bvalid;
   assign data.bresp    = cache.bresp;
   assign cache.bready  = data.bready;

   assign instr.awready = 1'b0;
   assign instr.wready  = 1'b0;
   assign instr.bvalid  = 1'b0;
   assign instr.bresp   = 2'b00;

   logic unused_instr_wr;
   assign unused_instr_wr = ^{instr.awvalid, instr.awaddr, instr.awprot, instr.wvalid,
                              instr.wdata, instr.wstrb, instr.bready};

   assign ar_hs_c = cache.arvalid & cache.arready;
   assign r_hs_c  = cache.rvalid & cache.rready;
   assign aw_hs_c = cache.awvalid & cache.awready;
   assign b_hs_c  = cache.bvalid & cache.bready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      wr_pending_d = wr_pending_q;
      case (state_q)
         IDLE: if (start_c) begin
            state_d = ADDR;
            grant_d = pick_c;
         end
         ADDR: if (ar_hs_c) state_d = RESP;
         RESP: if (r_hs_c) begin
            state_d = IDLE;
            grant_d = GRANT_NONE;
         end
         default: begin
            state_d = IDLE;
            grant_d = GRANT_NONE;
         end
      endcase
      if (aw_hs_c && !b_hs_c && (wr_pending_q < WPEND_W'(MAX_WR)))
         wr_pending_d = wr_pending_q + WPEND_W'(1);
      else if (b_hs_c && !aw_hs_c && (wr_pending_q != '0))
         wr_pending_d = wr_pending_q - WPEND_W'(1);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= IDLE;
         grant_q      <= GRANT_NONE;
         wr_pending_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         wr_pending_q <= wr_pending_d;
      end
   end

   assign grant      = grant_q;
   assign wr_pending = wr_pending_q;

   // The granted master must hold arvalid until the address is taken
   a_arvalid_hold: assert property (@(posedge aclk) disable iff (areset)
      (state_q == ADDR) |-> cache.arvalid);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a transaction-level reference model.
module tb_bus_arbiter;
   localparam int unsigned MAX_WR = 2;
   localparam bit PRIO_DATA = 1'b1;

   logic       aclk, areset;
   logic [1:0] grant;
   logic [2:0] wr_pending;

   axi instr_if();
   axi data_if();
   axi cache_if();

   bus_arbiter #(.MAX_WR(MAX_WR), .PRIO_DATA(PRIO_DATA)) dut (
      .aclk(aclk), .areset(areset), .instr(instr_if), .data(data_if),
      .cache(cache_if), .grant(grant), .wr_pending(wr_pending));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int nvec = 0, nerr = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
   endfunction

   // Reference model: who owns the read path, whether its address is taken, writes in flight
   int m_owner = 0;   // 0 none, 1 instr, 2 data
   bit m_ar_done = 0;
   int m_pend = 0;
   bit m_last_data = 0;

   typedef struct packed {
      logic [1:0]  grant;
      logic        c_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, c_rready;
      logic        c_awvalid, d_awready, c_wvalid, d_wready, start;
      logic [1:0]  winner;
      logic [31:0] c_araddr;
   } exp_t;

   function automatic exp_t model_eval();
      exp_t e;
      bit reading, wr_ok;
      e = '0;
      reading     = (m_owner != 0);
      e.grant     = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      e.c_araddr  = (m_owner == 2) ? data_if.araddr : instr_if.araddr;
      e.c_arvalid = reading && !m_ar_done &&
                    ((m_owner == 2) ? data_if.arvalid : instr_if.arvalid);
      e.i_arready = (m_owner == 1) && !m_ar_done && cache_if.arready;
      e.d_arready = (m_owner == 2) && !m_ar_done && cache_if.arready;
      e.i_rvalid  = (m_owner == 1) && m_ar_done && cache_if.rvalid;
      e.d_rvalid  = (m_owner == 2) && m_ar_done && cache_if.rvalid;
      e.c_rready  = reading && m_ar_done &&
                    ((m_owner == 2) ? data_if.rready : instr_if.rready);
      e.start     = !reading && (m_pend == 0) && (instr_if.arvalid || data_if.arvalid);
      wr_ok       = !areset && !reading && !e.start && (m_pend < MAX_WR);
      e.c_awvalid = data_if.awvalid && wr_ok;
      e.d_awready = cache_if.awready && wr_ok;
      e.c_wvalid  = data_if.wvalid && wr_ok;
      e.d_wready  = cache_if.wready && wr_ok;
      if (instr_if.arvalid && data_if.arvalid) begin
`ifdef BUS_ARBITER_RR_EN
         e.winner = m_last_data ? 2'd1 : 2'd2;
`else
         e.winner = PRIO_DATA ? 2'd2 : 2'd1;
`endif
      end else begin
         e.winner = data_if.arvalid ? 2'd2 : 2'd1;
      end
      return e;
   endfunction

   always @(posedge aclk) begin
      exp_t e;
      bit aw_hs, b_hs;
      e = model_eval();
      if (areset) begin
         m_owner = 0; m_ar_done = 0; m_pend = 0; m_last_data = 0;
      end else begin
         aw_hs = e.c_awvalid && cache_if.awready;
         b_hs  = cache_if.bvalid && data_if.bready;
         if (e.start) begin
            m_owner = int'(e.winner);
            m_last_data = (e.winner == 2'd2);
         end else if (m_owner != 0 && !m_ar_done && e.c_arvalid && cache_if.arready) begin
            m_ar_done = 1;
         end else if (m_owner != 0 && m_ar_done && cache_if.rvalid && e.c_rready) begin
            m_owner = 0; m_ar_done = 0;
         end
         if (aw_hs && !b_hs && m_pend < MAX_WR) m_pend++;
         else if (b_hs && !aw_hs && m_pend > 0) m_pend--;
      end
   end

   // Per-cycle compare of every arbiter output against the model
   always @(negedge aclk) begin
      exp_t e;
      if (mon_en) begin
         e = model_eval();
         chk("grant", 32'(grant), 32'(e.grant));
         chk("wr_pending", 32'(wr_pending), 32'(m_pend));
         chk("c_arvalid", 32'(cache_if.arvalid), 32'(e.c_arvalid));
         if (e.c_arvalid) chk("c_araddr", cache_if.araddr, e.c_araddr);
         chk("i_arready", 32'(instr_if.arready), 32'(e.i_arready));
         chk("d_arready", 32'(data_if.arready), 32'(e.d_arready));
         chk("i_rvalid", 32'(instr_if.rvalid), 32'(e.i_rvalid));
         chk("d_rvalid", 32'(data_if.rvalid), 32'(e.d_rvalid));
         chk("c_rready", 32'(cache_if.rready), 32'(e.c_rready));
         chk("c_awvalid", 32'(cache_if.awvalid), 32'(e.c_awvalid));
         chk("d_awready", 32'(data_if.awready), 32'(e.d_awready));
         chk("c_wvalid", 32'(cache_if.wvalid), 32'(e.c_wvalid));
         chk("d_wready", 32'(data_if.wready), 32'(e.d_wready));
         chk("d_bvalid", 32'(data_if.bvalid), 32'(cache_if.bvalid));
         chk("i_wr_ch", 32'({instr_if.awready, instr_if.wready, instr_if.bvalid}), 32'd0);
      end
   end

   // Handshake flags sampled on the active edge
   logic i_ar_seen, d_ar_seen, c_ar_seen, c_r_seen, i_r_seen, d_aw_seen, c_b_seen;
   logic [31:0] c_ar_addr, i_r_data, c_aw_addr, c_wdata;
   logic [3:0]  c_wstrb;
   always @(posedge aclk) begin
      i_ar_seen <= instr_if.arvalid & instr_if.arready;
      d_ar_seen <= data_if.arvalid & data_if.arready;
      c_ar_seen <= cache_if.arvalid & cache_if.arready;
      c_ar_addr <= cache_if.araddr;
      c_r_seen  <= cache_if.rvalid & cache_if.rready;
      i_r_seen  <= instr_if.rvalid & instr_if.rready;
      i_r_data  <= instr_if.rdata;
      d_aw_seen <= data_if.awvalid & data_if.awready;
      c_b_seen  <= cache_if.bvalid & cache_if.bready;
      if (cache_if.awvalid & cache_if.awready) begin
         c_aw_addr <= cache_if.awaddr;
         c_wdata   <= cache_if.wdata;
         c_wstrb   <= cache_if.wstrb;
      end
   end

   int rlat = 1, rcnt = 0, wr_left = 0;
   bit rpend = 0;
   logic [31:0] rad;

   // One clock: cache responder plus master valid handling
   task automatic tick();
      @(posedge aclk); #1;
      if (areset) begin
         rpend = 0; cache_if.rvalid = 1'b0;
      end else begin
         if (c_r_seen) cache_if.rvalid = 1'b0;
         if (c_ar_seen) begin rpend = 1; rcnt = rlat; rad = c_ar_addr; end
         if (rpend) begin
            if (rcnt <= 1) begin
               cache_if.rvalid = 1'b1; cache_if.rdata = mem(rad); rpend = 0;
            end else rcnt--;
         end
      end
      if (i_ar_seen) instr_if.arvalid = 1'b0;
      if (d_ar_seen) data_if.arvalid = 1'b0;
      if (d_aw_seen) begin
         wr_left--;
         if (wr_left <= 0) data_if.awvalid = 1'b0;
         else begin data_if.awaddr += 32'd4; data_if.wdata += 32'd1; end
         data_if.wvalid = data_if.awvalid;
      end
      if (c_b_seen) cache_if.bvalid = 1'b0;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [31:0] d, input int n);
      data_if.awaddr = a; data_if.wdata = d; data_if.wstrb = 4'hF;
      wr_left = n; data_if.awvalid = 1'b1; data_if.wvalid = 1'b1;
   endtask

   logic [1:0] exp_g;

   initial begin
      areset = 1'b1;
      {instr_if.arvalid, instr_if.awvalid, instr_if.wvalid} = '0;
      instr_if.araddr = '0; instr_if.arprot = '0; instr_if.rready = 1'b1;
      instr_if.awaddr = '0; instr_if.awprot = '0; instr_if.wdata = '0;
      instr_if.wstrb = '0; instr_if.bready = 1'b1;
      {data_if.arvalid, data_if.awvalid, data_if.wvalid} = '0;
      data_if.araddr = '0; data_if.arprot = '0; data_if.rready = 1'b1;
      data_if.awaddr = '0; data_if.awprot = '0; data_if.wdata = '0;
      data_if.wstrb = '0; data_if.bready = 1'b1;
      cache_if.arready = 1'b1; cache_if.rvalid = 1'b0; cache_if.rdata = '0;
      cache_if.rresp = '0; cache_if.awready = 1'b1; cache_if.wready = 1'b1;
      cache_if.bvalid = 1'b0; cache_if.bresp = '0;
      tick(); mon_en = 1'b1; tick();
      @(negedge aclk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_wrp", 32'(wr_pending), 32'd0);
      chk("rst_awready", 32'(data_if.awready), 32'd0);
      areset = 1'b0;
      tick();

      // single instr read
      instr_if.araddr = 32'h100; instr_if.arvalid = 1'b1;
      @(negedge aclk); chk("t1_g0", 32'(grant), 32'h0);
      tick(); @(negedge aclk); chk("t1_g1", 32'(grant), 32'h1);
      tick(); @(negedge aclk);
      chk("t1_g2", 32'(grant), 32'h1);
      chk("t1_rvalid", 32'(instr_if.rvalid), 32'h1);
      chk("t1_rdata", instr_if.rdata, 32'hDEADBEEF);
      chk("t1_drvalid", 32'(data_if.rvalid), 32'h0);
      tick(); @(negedge aclk); chk("t1_g3", 32'(grant), 32'h0);

      // contention: data first, instr after the data R handshake
      data_if.araddr = 32'h200; data_if.arvalid = 1'b1;
      instr_if.araddr = 32'h104; instr_if.arvalid = 1'b1;
      tick(); @(negedge aclk);
      chk("t2_addr0", cache_if.araddr, 32'h200); chk("t2_g0", 32'(grant), 32'h2);
      tick(); tick(); tick(); @(negedge aclk);
      chk("t2_addr1", cache_if.araddr, 32'h104); chk("t2_g1", 32'(grant), 32'h1);
      tick(); tick();
      // repeated contention: data wins (instr was last), then data re-requests against instr
      data_if.araddr = 32'h208; data_if.arvalid = 1'b1;
      instr_if.araddr = 32'h10C; instr_if.arvalid = 1'b1;
      tick(); @(negedge aclk); chk("t2_g2", 32'(grant), 32'h2);
      tick(); tick();
      data_if.araddr = 32'h20C; data_if.arvalid = 1'b1;
      tick(); @(negedge aclk);
`ifdef BUS_ARBITER_RR_EN
      exp_g = 2'b01;
`else
      exp_g = 2'b10;
`endif
      chk("t2_g3", 32'(grant), 32'(exp_g));
      repeat (8) tick();

      // write blocks a later read until B
      start_write(32'h300, 32'h12345678, 1);
      @(negedge aclk); chk("t3_awv", 32'(cache_if.awvalid), 32'h1);
      tick();
      chk("t3_awaddr", c_aw_addr, 32'h300); chk("t3_wdata", c_wdata, 32'h12345678);
      chk("t3_wstrb", 32'(c_wstrb), 32'hF);
      instr_if.araddr = 32'h110; instr_if.arvalid = 1'b1;
      repeat (4) begin
         @(negedge aclk); chk("t3_blk", 32'(cache_if.arvalid), 32'h0);
         chk("t3_wrp1", 32'(wr_pending), 32'h1);
         tick();
      end
      cache_if.bvalid = 1'b1;
      tick(); @(negedge aclk);
      chk("t3_wrp0", 32'(wr_pending), 32'h0); chk("t3_arv0", 32'(cache_if.arvalid), 32'h0);
      tick(); @(negedge aclk);
      chk("t3_arv1", 32'(cache_if.arvalid), 32'h1); chk("t3_addr", cache_if.araddr, 32'h110);
      repeat (3) tick();

      // write limit
      start_write(32'h400, 32'h1, 3);
      tick(); tick(); tick(); @(negedge aclk);
      chk("t4_wrp2", 32'(wr_pending), 32'h2); chk("t4_awrdy", 32'(data_if.awready), 32'h0);
      chk("t4_left", 32'(wr_left), 32'h1);
      cache_if.bvalid = 1'b1;
      tick(); @(negedge aclk); chk("t4_wrp1", 32'(wr_pending), 32'h1);
      tick(); @(negedge aclk);
      chk("t4_left0", 32'(wr_left), 32'h0); chk("t4_wrp2b", 32'(wr_pending), 32'h2);
      cache_if.bvalid = 1'b1; tick(); cache_if.bvalid = 1'b1; tick();
      @(negedge aclk); chk("t4_drain", 32'(wr_pending), 32'h0);

      // simultaneous AW and B at wr_pending=1
      start_write(32'h500, 32'h2, 1);
      tick(); @(negedge aclk); chk("t5_wrp1", 32'(wr_pending), 32'h1);
      start_write(32'h504, 32'h3, 1); cache_if.bvalid = 1'b1;
      @(negedge aclk); chk("t5_awv", 32'(cache_if.awvalid), 32'h1);
      tick(); @(negedge aclk); chk("t5_same", 32'(wr_pending), 32'h1);
      cache_if.bvalid = 1'b1; tick();
      @(negedge aclk); chk("t5_drain", 32'(wr_pending), 32'h0);

      // reset while waiting in RESP
      rlat = 20;
      instr_if.araddr = 32'h120; instr_if.arvalid = 1'b1;
      tick(); tick(); @(negedge aclk);
      chk("t6_g", 32'(grant), 32'h1); chk("t6_rv", 32'(cache_if.rvalid), 32'h0);
      areset = 1'b1; tick(); areset = 1'b0;
      @(negedge aclk);
      chk("t6_g0", 32'(grant), 32'h0); chk("t6_wrp", 32'(wr_pending), 32'h0);
      chk("t6_arv", 32'(cache_if.arvalid), 32'h0); chk("t6_rr", 32'(cache_if.rready), 32'h0);
      chk("t6_iar", 32'(instr_if.arready), 32'h0);
      rlat = 1;
      instr_if.araddr = 32'h124; instr_if.arvalid = 1'b1;
      tick(); tick(); tick();
      chk("t6_rseen", 32'(i_r_seen), 32'h1); chk("t6_rdata", i_r_data, 32'hC0DE0124);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
